// File: rtl/morse_rx_decoder.sv
// Morse receiver: times marks/gaps on a keyed line in Morse units and emits ASCII characters.
// Optional MORSE_RX_UNKNOWN_EN: unknown or overflowed characters emit '?' instead of being dropped.
module morse_rx_decoder #(
  parameter int unsigned CLKS_PER_UNIT = 5000000,
  parameter int unsigned DASH_MIN      = 2,
  parameter int unsigned CHAR_GAP      = 3,
  parameter int unsigned WORD_GAP      = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [6:0] char_out,
  output logic       char_valid,
  output logic       busy
);

  localparam int unsigned PW = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
  localparam logic [PW-1:0] P_LAST   = PW'(CLKS_PER_UNIT - 1);
  // The edge cycle itself is the first prescaler tick, so N units of level give unit_cnt=N at the next edge.
  localparam logic [PW-1:0] P_RELOAD = (CLKS_PER_UNIT > 1) ? PW'(1) : '0;
  localparam logic [2:0]    U_RELOAD = (CLKS_PER_UNIT > 1) ? 3'd0 : 3'd1;

  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD_WAIT} state_t;

  state_t        state, state_nx;
  logic          key_m, key_s, key_d;
  logic          rise, fall, key_edge;
  logic [PW-1:0] pcnt;
  logic [2:0]    unit_cnt;
  logic [2:0]    sym_len;
  logic [4:0]    sym_bits;
  logic          ovf;
  logic          is_dash, char_hit, word_hit;
  logic          do_append, do_emit, clr_sym;
  logic [6:0]    emit_code;
  logic          lut_ok;
  logic [6:0]    lut_code;

  assign rise     = key_s & ~key_d;
  assign fall     = ~key_s & key_d;
  assign key_edge = rise | fall;
  assign is_dash  = 32'(unit_cnt) >= DASH_MIN;
  assign char_hit = 32'(unit_cnt) >= CHAR_GAP;
  assign word_hit = 32'(unit_cnt) >= WORD_GAP;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_m    <= 1'b0;
      key_s    <= 1'b0;
      key_d    <= 1'b0;
      pcnt     <= '0;
      unit_cnt <= '0;
    end else begin
      key_m <= key_in;
      key_s <= key_m;
      key_d <= key_s;
      if (key_edge) begin
        pcnt     <= P_RELOAD;
        unit_cnt <= U_RELOAD;
      end else if (pcnt == P_LAST) begin
        pcnt <= '0;
        if (unit_cnt != 3'd7) unit_cnt <= unit_cnt + 3'd1;
      end else begin
        pcnt <= pcnt + PW'(1);
      end
    end
  end

  always_comb begin
    lut_ok   = 1'b1;
    lut_code = '0;
    unique case ({sym_len, sym_bits})
      {3'd1, 5'b00000}: lut_code = 7'h45; // E
      {3'd1, 5'b00001}: lut_code = 7'h54; // T
      {3'd2, 5'b00000}: lut_code = 7'h49; // I
      {3'd2, 5'b00001}: lut_code = 7'h41; // A
      {3'd2, 5'b00010}: lut_code = 7'h4E; // N
      {3'd2, 5'b00011}: lut_code = 7'h4D; // M
      {3'd3, 5'b00000}: lut_code = 7'h53; // S
      {3'd3, 5'b00001}: lut_code = 7'h55; // U
      {3'd3, 5'b00010}: lut_code = 7'h52; // R
      {3'd3, 5'b00011}: lut_code = 7'h57; // W
      {3'd3, 5'b00100}: lut_code = 7'h44; // D
      {3'd3, 5'b00101}: lut_code = 7'h4B; // K
      {3'd3, 5'b00110}: lut_code = 7'h47; // G
      {3'd3, 5'b00111}: lut_code = 7'h4F; // O
      {3'd4, 5'b00000}: lut_code = 7'h48; // H
      {3'd4, 5'b00001}: lut_code = 7'h56; // V
      {3'd4, 5'b00010}: lut_code = 7'h46; // F
      {3'd4, 5'b00100}: lut_code = 7'h4C; // L
      {3'd4, 5'b00110}: lut_code = 7'h50; // P
      {3'd4, 5'b00111}: lut_code = 7'h4A; // J
      {3'd4, 5'b01000}: lut_code = 7'h42; // B
      {3'd4, 5'b01001}: lut_code = 7'h58; // X
      {3'd4, 5'b01010}: lut_code = 7'h43; // C
      {3'd4, 5'b01011}: lut_code = 7'h59; // Y
      {3'd4, 5'b01100}: lut_code = 7'h5A; // Z
      {3'd4, 5'b01101}: lut_code = 7'h51; // Q
      {3'd5, 5'b11111}: lut_code = 7'h30;
      {3'd5, 5'b01111}: lut_code = 7'h31;
      {3'd5, 5'b00111}: lut_code = 7'h32;
      {3'd5, 5'b00011}: lut_code = 7'h33;
      {3'd5, 5'b00001}: lut_code = 7'h34;
      {3'd5, 5'b00000}: lut_code = 7'h35;
      {3'd5, 5'b10000}: lut_code = 7'h36;
      {3'd5, 5'b11000}: lut_code = 7'h37;
      {3'd5, 5'b11100}: lut_code = 7'h38;
      {3'd5, 5'b11110}: lut_code = 7'h39;
      default:          lut_ok   = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    do_append = 1'b0;
    do_emit   = 1'b0;
    clr_sym   = 1'b0;
    emit_code = 7'h20;
    unique case (state)
      IDLE: if (rise) state_nx = MARK;
      MARK: if (fall) begin
        do_append = 1'b1;
        state_nx  = GAP;
      end
      GAP: begin
        if (rise) begin
          state_nx = MARK;
        end else if (char_hit) begin
          clr_sym  = 1'b1;
          state_nx = WORD_WAIT;
`ifdef MORSE_RX_UNKNOWN_EN
          do_emit   = 1'b1;
          emit_code = (lut_ok && !ovf) ? lut_code : 7'h3F;
`else
          do_emit   = lut_ok && !ovf;
          emit_code = lut_code;
`endif
        end
      end
      WORD_WAIT: begin
        if (rise) begin
          state_nx = MARK;
        end else if (word_hit) begin
          do_emit  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_out   <= '0;
      char_valid <= 1'b0;
      sym_len    <= '0;
      sym_bits   <= '0;
      ovf        <= 1'b0;
    end else begin
      char_valid <= do_emit;
      if (do_emit) char_out <= emit_code;
      if (clr_sym) begin
        sym_len  <= '0;
        sym_bits <= '0;
        ovf      <= 1'b0;
      end else if (do_append) begin
        if (sym_len < 3'd5) begin
          sym_bits <= {sym_bits[3:0], is_dash};
          sym_len  <= sym_len + 3'd1;
        end else begin
          ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Bench for morse_rx_decoder: directed and randomized keying checked against a Morse-table model.
module tb_morse_rx_decoder;

  localparam int CPU      = 4;
  localparam int CHAR_MIN = 3 * CPU + 1;  // low cycles needed to end a character
  localparam int WORD_MIN = 7 * CPU + 1;  // low cycles needed to emit a space

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_in;
  logic [6:0] char_out;
  logic       char_valid;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;
  int n_valid = 0;
  logic [7:0] exp_q[$];

  string morse_tab[36] = '{
    ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
    "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
    "..-", "...-", ".--", "-..-", "-.--", "--..",
    "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...", "---..", "----."
  };
  string bad_tab[3] = '{"......", "..--", ".-.-"};

  morse_rx_decoder #(
    .CLKS_PER_UNIT(CPU),
    .DASH_MIN(2),
    .CHAR_GAP(3),
    .WORD_GAP(7)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .char_out(char_out),
    .char_valid(char_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s got %h want %h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] code_of(input int idx);
    return (idx < 26) ? 8'(65 + idx) : 8'(48 + idx - 26);
  endfunction

  function automatic int lookup(input string p);
    for (int i = 0; i < 36; i++) if (morse_tab[i] == p) return i;
    return -1;
  endfunction

  // Expected output for one character followed by `gap` low cycles.
  task automatic expect_char(input string p, input int gap);
    int idx;
    if (gap >= CHAR_MIN) begin
      idx = (p.len() <= 5) ? lookup(p) : -1;
      if (idx >= 0) exp_q.push_back(code_of(idx));
`ifdef MORSE_RX_UNKNOWN_EN
      else exp_q.push_back(8'h3F);
`endif
      if (gap >= WORD_MIN) exp_q.push_back(8'h20);
    end
  endtask

  task automatic hold(input logic v, input int n);
    key_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Zero length arguments select a random length within the legal class range.
  task automatic send_char(input string p, input int dot_len, input int dash_len,
                           input int intra, input int gap);
    for (int i = 0; i < p.len(); i++) begin
      int l;
      int g;
      if (p[i] == 8'h2D) l = (dash_len != 0) ? dash_len : int'($urandom_range(20, 8));
      else               l = (dot_len  != 0) ? dot_len  : int'($urandom_range(7, 2));
      hold(1'b1, l);
      if (i == p.len() - 1) g = gap;
      else g = (intra != 0) ? intra : int'($urandom_range(12, 2));
      hold(1'b0, g);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] want;
    if (rst_n === 1'b1 && char_valid === 1'b1) begin
      n_valid++;
      if (exp_q.size() > 0) want = exp_q.pop_front();
      else                  want = 8'hFF;
      check("char", {1'b0, char_out}, want);
    end
  end

  initial begin
    int base;
    rst_n  = 1'b0;
    key_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_char", {1'b0, char_out}, 8'h00);
    check("rst_valid", {7'b0, char_valid}, 8'h00);
    check("rst_busy", {7'b0, busy}, 8'h00);
    rst_n = 1'b1;
    hold(1'b0, 5);

    expect_char(".", 40);
    send_char(".", 4, 0, 0, 40);
    check("idle_busy", {7'b0, busy}, 8'h00);
    check("hold_char", {1'b0, char_out}, 8'h20);

    expect_char("-", 40);
    key_in = 1'b1;
    repeat (6) @(negedge clk);
    check("mark_busy", {7'b0, busy}, 8'h01);
    hold(1'b1, 6);
    hold(1'b0, 40);

    expect_char(".-", 14);
    send_char(".-", 4, 12, 4, 14);
    expect_char("-...", 40);
    send_char("-...", 4, 12, 4, 40);

    expect_char("-----", 40);
    send_char("-----", 4, 12, 4, 40);
    expect_char(".....", 40);
    send_char(".....", 4, 12, 4, 40);

    expect_char("......", 40);
    send_char("......", 4, 12, 4, 40);

    expect_char("-", 30);
    send_char("-", 4, 12, 4, 30);
    expect_char("-", 40);
    send_char("-", 4, 12, 4, 40);

    // Class boundaries: 7/8-cycle marks, 12-cycle element gap, 13/28/29-cycle gaps.
    expect_char("-.", 13);
    send_char("-.", 7, 8, 12, 13);
    expect_char("...", 28);
    send_char("...", 7, 8, 12, 28);
    expect_char(".", 29);
    send_char(".", 7, 8, 12, 29);
    expect_char("-", 40);
    send_char("-", 4, 40, 4, 40);
    hold(1'b0, 10);
    check("bound_drain", 8'(exp_q.size()), 8'h00);

    key_in = 1'b1;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_char", {1'b0, char_out}, 8'h00);
    check("arst_valid", {7'b0, char_valid}, 8'h00);
    check("arst_busy", {7'b0, busy}, 8'h00);
    @(negedge clk);
    key_in = 1'b0;
    rst_n  = 1'b1;
    base   = n_valid;
    hold(1'b0, 40);
    check("arst_quiet", 8'(n_valid - base), 8'h00);

    for (int w = 0; w < 6; w++) begin
      int nch;
      nch = int'($urandom_range(3, 1));
      for (int c = 0; c < nch; c++) begin
        string p;
        int idx;
        int gap;
        if ($urandom_range(9, 0) == 0) begin
          p = bad_tab[$urandom_range(2, 0)];
        end else begin
          do idx = int'($urandom_range(35, 0)); while (idx == 29 || idx == 34);
          p = morse_tab[idx];
        end
        gap = (c == nch - 1) ? int'($urandom_range(45, WORD_MIN)) : int'($urandom_range(WORD_MIN - 1, CHAR_MIN));
        expect_char(p, gap);
        send_char(p, 0, 0, 0, gap);
      end
    end
    hold(1'b0, 10);
    check("final_drain", 8'(exp_q.size()), 8'h00);
    check("final_busy", {7'b0, busy}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
